// File: rtl/sync_ram_pkg.sv
// Shared sizing defaults and word/address types for the sync_ram storage block.
package sync_ram_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage : sync_ram_pkg

// File: rtl/sync_ram_array.sv
// Bare single-port storage array: synchronous write, registered read-first output.
// Kept free of reset on the array itself so synthesis maps it onto block RAM.
module sync_ram_array
    import sync_ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately never reset; a reset loop over every
    // word would stop the tools from inferring block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments make the read sample mem[addr] before this
    // edge's write lands, which is exactly the read-first behaviour we want.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            data_out <= '0;
        end else begin
            data_out <= mem[addr];
        end
    end

endmodule : sync_ram_array

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with one-cycle registered read and synchronous
// active-low reset that clears the output register but preserves contents.
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic array_we;
    logic rd_clr;

    // Writes are dropped while reset is held; the output register clears instead.
    assign array_we = we & rst_n;
    assign rd_clr   = ~rst_n;

    sync_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .we       (array_we),
        .rd_clr   (rd_clr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

`ifndef SYNTHESIS
    a_we_known : assert property (@(posedge clk) rst_n |-> !$isunknown(we))
        else $error("sync_ram: we is X/Z while out of reset");

    a_addr_known : assert property (@(posedge clk) (rst_n && we) |-> !$isunknown(addr))
        else $error("sync_ram: addr is X/Z during a write");

    a_reset_clears : assert property (@(posedge clk) !rst_n |=> (data_out == '0))
        else $error("sync_ram: data_out not zero after reset edge");
`endif

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: directed scenarios followed by random traffic,
// all checked against a word-level reference model of the RAM.
module tb_sync_ram;
    import sync_ram_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      we;
    ram_addr_t addr;
    ram_word_t data_in;
    ram_word_t data_out;

    // Reference model: contents plus which words have ever been written.
    ram_word_t model_mem [RAM_DEPTH];
    bit        model_written [RAM_DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    sync_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input ram_word_t observed, input ram_word_t expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock of activity: drive, take the edge, then compare data_out with
    // what the model says the RAM must present after that edge.
    task automatic step(input string tag, input logic r, input logic w,
                        input ram_addr_t a, input ram_word_t d);
        ram_word_t exp_val;
        bit        known;
        rst_n   = r;
        we      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_val = '0;
            known   = 1'b1;
        end else begin
            exp_val = model_mem[a];
            known   = model_written[a];
            if (w) begin
                model_mem[a]     = d;
                model_written[a] = 1'b1;
            end
        end
        if (known) check(tag, data_out, exp_val);
    endtask

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            model_mem[i]     = '0;
            model_written[i] = 1'b0;
        end
        rst_n   = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;

        // Reset for two edges, then a first write and read-back.
        step("reset0", 1'b0, 1'b0, 8'd0, 32'h0);
        step("reset1", 1'b0, 1'b0, 8'd0, 32'h0);
        check("reset_out", data_out, 32'h0);
        step("wr10", 1'b1, 1'b1, 8'd10, 32'h12345678);
        step("rd10", 1'b1, 1'b0, 8'd10, 32'h0);
        check("rd10_const", data_out, 32'h12345678);

        // Second location, and the first one is still intact.
        step("wr20", 1'b1, 1'b1, 8'd20, 32'hAABBCCDD);
        step("rd20", 1'b1, 1'b0, 8'd20, 32'h0);
        check("rd20_const", data_out, 32'hAABBCCDD);
        step("rd10b", 1'b1, 1'b0, 8'd10, 32'h0);
        check("rd10b_const", data_out, 32'h12345678);

        // Read-during-write on the same address returns old data first.
        step("wr5a", 1'b1, 1'b1, 8'd5, 32'h11111111);
        step("rdw5", 1'b1, 1'b1, 8'd5, 32'h22222222);
        check("rdw5_old", data_out, 32'h11111111);
        step("rd5", 1'b1, 1'b0, 8'd5, 32'h0);
        check("rd5_new", data_out, 32'h22222222);

        // Address extremes, no aliasing.
        step("wr0", 1'b1, 1'b1, 8'd0, 32'hDEADBEEF);
        step("wr255", 1'b1, 1'b1, 8'd255, 32'hCAFEF00D);
        step("rd0", 1'b1, 1'b0, 8'd0, 32'h0);
        check("rd0_const", data_out, 32'hDEADBEEF);
        step("rd255", 1'b1, 1'b0, 8'd255, 32'h0);
        check("rd255_const", data_out, 32'hCAFEF00D);

        // Reset mid-operation drops the write and keeps contents.
        step("wr7", 1'b1, 1'b1, 8'd7, 32'h01010101);
        step("rst_wr7", 1'b0, 1'b1, 8'd7, 32'hFFFFFFFF);
        check("rst_mid_out", data_out, 32'h0);
        step("rd7", 1'b1, 1'b0, 8'd7, 32'h0);
        check("rd7_kept", data_out, 32'h01010101);

        // Back-to-back writes then back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            step("b2b_wr", 1'b1, 1'b1, ram_addr_t'(i), ram_word_t'(i) * 32'h01010101);
        end
        for (int i = 0; i < 16; i++) begin
            step("b2b_rd", 1'b1, 1'b0, ram_addr_t'(i), 32'h0);
            check("b2b_const", data_out, ram_word_t'(i) * 32'h01010101);
        end

        // Random traffic over a narrow address window to force frequent reuse,
        // with occasional resets and hits at the top of the address space.
        for (int i = 0; i < 400; i++) begin
            logic      r;
            logic      w;
            ram_addr_t a;
            r = ($urandom_range(0, 24) != 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 7) == 0) ? ram_addr_t'(8'hF8 + $urandom_range(0, 7))
                                            : ram_addr_t'($urandom_range(0, 31));
            step("rand", r, w, a, ram_word_t'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_ram
